// File: rtl/bids_pkg.sv
// Shared opcode, state and abort-code definitions for the bid host sequencer.
package bids_pkg;

    typedef enum logic [3:0] {
        OP_NOOP      = 4'd0,
        OP_UNLOCK    = 4'd1,
        OP_LOCK      = 4'd2,
        OP_LOADX     = 4'd3,
        OP_LOADY     = 4'd4,
        OP_LOADZ     = 4'd5,
        OP_SETMASK   = 4'd6,
        OP_SETTIMER  = 4'd7,
        OP_BIDCHARGE = 4'd8
    } op_e;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LDX    = 4'd1,
        LDY    = 4'd2,
        LDZ    = 4'd3,
        MASK   = 4'd4,
        TIMER  = 4'd5,
        COST   = 4'd6,
        LOCK   = 4'd7,
        ROUND  = 4'd8,
        CLOSE  = 4'd9,
        SAMPLE = 4'd10,
        DONE   = 4'd11,
        ABORT  = 4'd12
    } state_e;

    localparam logic [2:0] SERR_NONE         = 3'b000;
    localparam logic [2:0] SERR_NO_ROUNDOVER = 3'b101;
    localparam logic [2:0] SERR_NOT_READY    = 3'b110;

endpackage

// File: rtl/bids_rnd_timer.sv
// Loadable down-counter that paces the active phase of a round; zero_o flags the last cycle.
module bids_rnd_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bids_host_sequencer.sv
// Host-side sequencer: programs the bid controller, runs N rounds, samples results, unlocks.
// Optional per-player win counters when BIDS_SEQ_WINSTAT_EN is defined.
module bids_host_sequencer
    import bids_pkg::*;
#(
    parameter int RND_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [31:0]      cfg_x,
    input  logic [31:0]      cfg_y,
    input  logic [31:0]      cfg_z,
    input  logic [2:0]       cfg_mask,
    input  logic [3:0]       cfg_timer,
    input  logic [31:0]      cfg_cost,
    input  logic [31:0]      cfg_key,
    input  logic [RND_W-1:0] cfg_rounds,
    input  logic [RND_W-1:0] cfg_len,
    input  logic             ready,
    input  logic [2:0]       err,
    input  logic             roundOver,
    input  logic [2:0]       win,
    input  logic [31:0]      maxBid,
    output logic [3:0]       C_op,
    output logic [31:0]      C_data,
    output logic             C_start,
    output logic             busy,
    output logic             done,
    output logic [2:0]       seq_err,
    output logic [2:0]       last_win,
    output logic [31:0]      last_max,
    output logic [RND_W-1:0] rnd_cnt
`ifdef BIDS_SEQ_WINSTAT_EN
    ,
    output logic [RND_W-1:0] x_wins,
    output logic [RND_W-1:0] y_wins,
    output logic [RND_W-1:0] z_wins
`endif
);

    localparam logic [RND_W-1:0] ONE = {{(RND_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [3:0]       c_op_q, c_op_d;
    logic [31:0]      c_data_q, c_data_d;
    logic             c_start_q, c_start_d;
    logic [2:0]       seq_err_q, seq_err_d;
    logic [2:0]       last_win_q;
    logic [31:0]      last_max_q;
    logic [RND_W-1:0] rnd_cnt_q;
    logic [RND_W-1:0] rounds_left_q;

    logic [31:0]      x_q, y_q, z_q, cost_q, key_q;
    logic [2:0]       mask_q;
    logic [3:0]       timer_q;
    logic [RND_W-1:0] len_q;

    logic             accept, sample, timer_load, timer_dec, timer_zero;
    logic [RND_W-1:0] len_eff;

    // Output decode needs the values being captured this cycle when leaving IDLE.
    logic [31:0]      x_d, y_d, z_d, cost_d, key_d;
    logic [2:0]       mask_d;
    logic [3:0]       timer_d;

    assign x_d     = accept ? cfg_x     : x_q;
    assign y_d     = accept ? cfg_y     : y_q;
    assign z_d     = accept ? cfg_z     : z_q;
    assign cost_d  = accept ? cfg_cost  : cost_q;
    assign key_d   = accept ? cfg_key   : key_q;
    assign mask_d  = accept ? cfg_mask  : mask_q;
    assign timer_d = accept ? cfg_timer : timer_q;
    assign len_eff = (len_q == '0) ? ONE : len_q;

    bids_rnd_timer #(.W(RND_W)) u_rnd_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (timer_load),
        .load_val_i (len_eff),
        .dec_i      (timer_dec),
        .zero_o     (timer_zero)
    );

    always_comb begin
        state_d    = state_q;
        seq_err_d  = seq_err_q;
        accept     = 1'b0;
        sample     = 1'b0;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (go && ready) begin
                    accept    = 1'b1;
                    seq_err_d = SERR_NONE;
                    state_d   = LDX;
                end
            end
            LDX, LDY, LDZ, MASK, TIMER, COST, LOCK: begin
                if (!ready) begin
                    seq_err_d = SERR_NOT_READY;
                    state_d   = ABORT;
                end else if (err != 3'b000) begin
                    seq_err_d = err;
                    state_d   = ABORT;
                end else begin
                    case (state_q)
                        LDX:     state_d = LDY;
                        LDY:     state_d = LDZ;
                        LDZ:     state_d = MASK;
                        MASK:    state_d = TIMER;
                        TIMER:   state_d = COST;
                        COST:    state_d = LOCK;
                        default: begin
                            state_d    = ROUND;
                            timer_load = 1'b1;
                        end
                    endcase
                end
            end
            // err is deliberately not checked here: bid+retract collisions raise it legitimately.
            ROUND: begin
                if (timer_zero) begin
                    state_d = CLOSE;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            CLOSE: state_d = SAMPLE;
            SAMPLE: begin
                if (!roundOver) begin
                    seq_err_d = SERR_NO_ROUNDOVER;
                    state_d   = ABORT;
                end else begin
                    sample = 1'b1;
                    if (rounds_left_q > ONE) begin
                        state_d    = ROUND;
                        timer_load = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            ABORT: begin
                if (go) begin
                    seq_err_d = SERR_NONE;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the destination state so they line up with it once registered.
    always_comb begin
        c_op_d    = OP_NOOP;
        c_data_d  = '0;
        c_start_d = 1'b0;
        case (state_d)
            LDX:    begin c_op_d = OP_LOADX;     c_data_d = x_d;                end
            LDY:    begin c_op_d = OP_LOADY;     c_data_d = y_d;                end
            LDZ:    begin c_op_d = OP_LOADZ;     c_data_d = z_d;                end
            MASK:   begin c_op_d = OP_SETMASK;   c_data_d = {29'd0, mask_d};    end
            TIMER:  begin c_op_d = OP_SETTIMER;  c_data_d = {28'd0, timer_d};   end
            COST:   begin c_op_d = OP_BIDCHARGE; c_data_d = cost_d;             end
            LOCK:   begin c_op_d = OP_LOCK;      c_data_d = key_d;              end
            ROUND:  c_start_d = 1'b1;
            DONE:   begin c_op_d = OP_UNLOCK;    c_data_d = key_d;              end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            c_op_q        <= '0;
            c_data_q      <= '0;
            c_start_q     <= 1'b0;
            seq_err_q     <= '0;
            last_win_q    <= '0;
            last_max_q    <= '0;
            rnd_cnt_q     <= '0;
            rounds_left_q <= '0;
        end else begin
            state_q   <= state_d;
            c_op_q    <= c_op_d;
            c_data_q  <= c_data_d;
            c_start_q <= c_start_d;
            seq_err_q <= seq_err_d;
            if (accept) begin
                rnd_cnt_q     <= '0;
                rounds_left_q <= (cfg_rounds == '0) ? ONE : cfg_rounds;
            end else if (sample) begin
                last_win_q    <= win;
                last_max_q    <= maxBid;
                rounds_left_q <= rounds_left_q - ONE;
                if (rnd_cnt_q != '1) begin
                    rnd_cnt_q <= rnd_cnt_q + ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            cost_q  <= '0;
            key_q   <= '0;
            mask_q  <= '0;
            timer_q <= '0;
            len_q   <= '0;
        end else if (accept) begin
            x_q     <= cfg_x;
            y_q     <= cfg_y;
            z_q     <= cfg_z;
            cost_q  <= cfg_cost;
            key_q   <= cfg_key;
            mask_q  <= cfg_mask;
            timer_q <= cfg_timer;
            len_q   <= cfg_len;
        end
    end

`ifdef BIDS_SEQ_WINSTAT_EN
    logic [RND_W-1:0] x_wins_q, y_wins_q, z_wins_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_wins_q <= '0;
            y_wins_q <= '0;
            z_wins_q <= '0;
        end else if (accept) begin
            x_wins_q <= '0;
            y_wins_q <= '0;
            z_wins_q <= '0;
        end else if (sample) begin
            if (win[2] && (x_wins_q != '1)) x_wins_q <= x_wins_q + ONE;
            if (win[1] && (y_wins_q != '1)) y_wins_q <= y_wins_q + ONE;
            if (win[0] && (z_wins_q != '1)) z_wins_q <= z_wins_q + ONE;
        end
    end

    assign x_wins = x_wins_q;
    assign y_wins = y_wins_q;
    assign z_wins = z_wins_q;
`endif

    assign C_op     = c_op_q;
    assign C_data   = c_data_q;
    assign C_start  = c_start_q;
    assign busy     = (state_q != IDLE) && (state_q != ABORT);
    assign done     = (state_q == DONE);
    assign seq_err  = seq_err_q;
    assign last_win = last_win_q;
    assign last_max = last_max_q;
    assign rnd_cnt  = rnd_cnt_q;

endmodule
